// File: rtl/game_packet_decoder.sv
// Receive-side game-state decoder: skips the MAC header, pulls a 48-bit payload
// from the RMII dibit stream, validates it and publishes the opponent's state.
module game_packet_decoder #(
  parameter int          HEADER_DIBITS  = 56,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic [10:0] opponent_x,
  output logic [10:0] opponent_y,
  output logic [8:0]  opponent_dir,
  output logic        opponent_stat,
  output logic        update_out,
  output logic        link_up,
  output logic [7:0]  err_count
);

  localparam int PAYLOAD_DIBITS = 24;
  localparam int HDR_W          = $clog2(HEADER_DIBITS + 1);
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HEADER_DIBITS - 1);
  localparam logic [4:0]       PAY_LAST = 5'(PAYLOAD_DIBITS - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [HDR_W-1:0] r_hdr_cnt;
  logic [4:0]       r_pay_cnt;
  logic [47:0]      r_shift;
  logic [TO_W-1:0]  r_to_cnt;
  logic [10:0]      r_x;
  logic [10:0]      r_y;
  logic [8:0]       r_dir;
  logic             r_stat;
  logic             r_update;
  logic             r_link;
  logic [7:0]       r_err;

  // Payload fields, MSB-first as received
  logic [7:0]  w_magic;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [8:0]  w_dir;
  logic        w_stat;
  logic [7:0]  w_csum_rx;
  logic [7:0]  w_csum_calc;
  logic        w_accept;
  logic        w_err_inc;

  assign w_magic   = r_shift[47:40];
  assign w_x       = r_shift[39:29];
  assign w_y       = r_shift[28:18];
  assign w_dir     = r_shift[17:9];
  assign w_stat    = r_shift[8];
  assign w_csum_rx = r_shift[7:0];

  always_comb begin
    w_csum_calc = 8'h00;
    for (int i = 0; i < 5; i++) begin
      w_csum_calc = w_csum_calc ^ r_shift[47-8*i -: 8];
    end
  end

  assign w_accept = (r_state == S_CHECK) && (w_magic == MAGIC) &&
                    (w_dir <= 9'd359) && (w_csum_calc == w_csum_rx);

  // Truncated header/payload and failed validation are the only error sources
  assign w_err_inc = ((r_state == S_HEADER)  && !axiiv) ||
                     ((r_state == S_PAYLOAD) && !axiiv) ||
                     ((r_state == S_CHECK)   && !w_accept);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_hdr_cnt <= '0;
      r_pay_cnt <= '0;
      r_shift   <= '0;
      r_to_cnt  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_dir     <= '0;
      r_stat    <= 1'b0;
      r_update  <= 1'b0;
      r_link    <= 1'b0;
      r_err     <= '0;
    end else begin
      r_update <= 1'b0;

      // An accept in the expiry cycle takes priority over the timeout
      if (w_accept) begin
        r_to_cnt <= '0;
        r_link   <= 1'b1;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (r_to_cnt == TO_LAST) begin
          r_link <= 1'b0;
        end
      end

      if (w_err_inc && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (axiiv) begin
            r_pay_cnt <= '0;
            if (HEADER_DIBITS == 1) begin
              r_state <= S_PAYLOAD;
            end else begin
              r_hdr_cnt <= HDR_W'(1);
              r_state   <= S_HEADER;
            end
          end
        end

        S_HEADER: begin
          if (!axiiv) begin
            r_state <= S_IDLE;
          end else if (r_hdr_cnt == HDR_LAST) begin
            r_pay_cnt <= '0;
            r_state   <= S_PAYLOAD;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 1'b1;
          end
        end

        S_PAYLOAD: begin
          if (!axiiv) begin
            r_state <= S_IDLE;
          end else begin
            r_shift <= {r_shift[45:0], axiid};
            if (r_pay_cnt == PAY_LAST) begin
              r_state <= S_CHECK;
            end else begin
              r_pay_cnt <= r_pay_cnt + 1'b1;
            end
          end
        end

        S_CHECK: begin
          if (w_accept) begin
            r_x      <= w_x;
            r_y      <= w_y;
            r_dir    <= w_dir;
            r_stat   <= w_stat;
            r_update <= 1'b1;
          end
          r_state <= axiiv ? S_DRAIN : S_IDLE;
        end

        S_DRAIN: begin
          if (!axiiv) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign opponent_x    = r_x;
  assign opponent_y    = r_y;
  assign opponent_dir  = r_dir;
  assign opponent_stat = r_stat;
  assign update_out    = r_update;
  assign link_up       = r_link;
  assign err_count     = r_err;

endmodule

// File: doc/game_packet_decoder.md
Name: game_packet_decoder

Overview:
- Receive-side counterpart to the game-state transmitter.
- Consumes the RMII receiver's post-preamble dibit stream, skips the MAC header, and extracts the opponent's game-state payload.
- Validates the payload (magic, range, checksum), then publishes registered opponent position, direction and status to track_view and racer_view.
- Tracks link liveness and counts bad frames.
- Runs on the 50 MHz eth_refclk domain.

Parameters:
- HEADER_DIBITS, 56, dibits skipped at frame start (14-byte MAC header).
- MAGIC, 8'hA5, required first payload byte.
- TIMEOUT_CYCLES, 5_000_000, cycles without a good packet before link_up drops (100 ms at 50 MHz).

Ports:
- clk_in  input  1  eth_refclk, 50 MHz.
- rst_in  input  1  asynchronous, active-high reset.
- axiiv  input  1  dibit valid; high for the whole frame body, low between frames.
- axiid  input  2  dibit, MSB-first ordering of the payload bitstream.
- opponent_x  output  11  last good x.
- opponent_y  output  11  last good y.
- opponent_dir  output  9  last good direction, degrees 0..359.
- opponent_stat  output  1  last good game status bit.
- update_out  output  1  one-cycle pulse when outputs change.
- link_up  output  1  high while good packets arrive within TIMEOUT_CYCLES.
- err_count  output  8  saturating count of rejected frames.

Behaviour:
- Reset (async, active-high):
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset mid-frame abandons the frame; it is not counted as an error.
- Payload layout, 48 bits = 24 dibits, first bit received is MSB:
  - magic[7:0], x[10:0], y[10:0], dir[8:0], stat, csum[7:0].
  - csum = XOR of the five preceding bytes (bits 47..8 split into bytes).
- States:
  - IDLE: on axiiv=1, count this dibit as header dibit 0 -> HEADER.
  - HEADER: count dibits while axiiv=1. After HEADER_DIBITS total -> PAYLOAD. axiiv=0 -> IDLE, err_count++.
  - PAYLOAD: shift axiid into a 48-bit register. On the 24th dibit -> CHECK. axiiv=0 earlier -> IDLE, err_count++ (short frame).
  - CHECK (one cycle): accept if magic==MAGIC, dir<=359 and csum matches.
    - Accept: register x, y, dir, stat; pulse update_out; clear the timeout counter; set link_up.
    - Reject: err_count++, outputs held.
    - Then -> DRAIN if axiiv=1, else IDLE.
  - DRAIN: ignore dibits (padding/FCS) until axiiv=0 -> IDLE.
- Latency: last payload dibit sampled at edge N; outputs and update_out are valid after edge N+1. update_out is high for exactly one cycle.
- Dibits arriving during the CHECK cycle are discarded; CHECK never stalls.
- A one-cycle axiiv low gap is a frame boundary; the next high starts a new frame from IDLE.
- Timeout counter:
  - Increments every cycle and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES clears link_up; position outputs hold their last values.
  - A good packet in the same cycle as the timeout wins: counter cleared, link_up stays 1.
- err_count saturates at 255; it does not wrap.

Test Plan:
- Good packet: header of 56 arbitrary dibits, then payload bytes A5 28 05 02 1D csum 97 (x=320, y=320, dir=270, stat=1), then 8 padding dibits -> one cycle after the last payload dibit: opponent_x=320, opponent_y=320, opponent_dir=270, opponent_stat=1, update_out=1 for 1 cycle, link_up=1, err_count=0.
- Same packet with csum 96 -> outputs unchanged, no update_out, err_count=1. Repeat with magic A4 -> err_count=2.
- dir=360 with a correct checksum -> rejected, err_count increments, opponent_dir keeps its previous value.
- axiiv drops after 10 payload dibits -> IDLE, err_count+1. An immediate good frame after a 1-cycle gap decodes correctly.
- Link timeout: good packet, then idle for TIMEOUT_CYCLES (override to 1000) -> link_up falls at cycle 1000, positions hold; the next good packet raises link_up again.
- Assert rst_in mid-PAYLOAD -> all outputs 0 immediately; after release, a good frame decodes normally. Also send 300 bad frames -> err_count=255.
